// File: rtl/corr_engine.sv
// Template cross-correlation engine: streams a TW x TH window from frame memory
// alongside the template and returns the sum of pixel products.
module corr_engine #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int TW      = 8,
  parameter int TH      = 8,
  parameter int PIX_W   = 8,
  parameter int ADDR_W  = 19,
  parameter int TADDR_W = 6,
  parameter int CORR_W  = 22
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iStart,
  input  logic [12:0]        iX,
  input  logic [12:0]        iY,
  output logic               oFrameRd,
  output logic [ADDR_W-1:0]  oFrameAddr,
  input  logic [PIX_W-1:0]   iFramePix,
  output logic [TADDR_W-1:0] oTmplAddr,
  input  logic [PIX_W-1:0]   iTmplPix,
  output logic [CORR_W-1:0]  oCorr,
  output logic               oCorrFinished,
  output logic               oBusy
);

  localparam int N     = TW * TH;
  localparam int COL_W = (TW > 1) ? $clog2(TW) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_frame_rd;
  logic [ADDR_W-1:0]   r_frame_addr;
  logic [ADDR_W-1:0]   r_row_base;
  logic [COL_W-1:0]    r_col;
  logic [TADDR_W-1:0]  r_k;
  logic                r_pix_vld;
  logic [CORR_W-1:0]   r_acc;
  logic [CORR_W-1:0]   r_corr;
  logic                r_fin;
  logic                r_busy;

  logic                w_in_bounds;
  logic                w_last;
  logic                w_col_wrap;
  logic [ADDR_W-1:0]   w_base;
  logic [CORR_W-1:0]   w_prod;
  logic [CORR_W-1:0]   w_acc_sum;

  assign w_in_bounds = ((32'(iX) + 32'(TW)) <= 32'(H_RES)) &&
                       ((32'(iY) + 32'(TH)) <= 32'(V_RES));
  // Single multiply per window; per-pixel addresses are built incrementally.
  assign w_base      = ADDR_W'(iY) * ADDR_W'(H_RES) + ADDR_W'(iX);
  assign w_last      = (r_k == TADDR_W'(N - 1));
  assign w_col_wrap  = (r_col == COL_W'(TW - 1));
  assign w_prod      = CORR_W'(iFramePix) * CORR_W'(iTmplPix);
  assign w_acc_sum   = r_acc + w_prod;

  // State register
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (iStart) begin
          if (w_in_bounds) begin
            w_state_nxt = ST_FETCH;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (w_last) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_DRAIN: w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Read issue, accumulation and result registers
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_frame_rd   <= 1'b0;
      r_frame_addr <= '0;
      r_row_base   <= '0;
      r_col        <= '0;
      r_k          <= '0;
      r_pix_vld    <= 1'b0;
      r_acc        <= '0;
      r_corr       <= '0;
      r_fin        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      // Memory data returns one cycle after the strobe.
      r_pix_vld <= r_frame_rd;
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_fin     <= (w_state_nxt == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (iStart && w_in_bounds) begin
            r_frame_rd   <= 1'b1;
            r_frame_addr <= w_base;
            r_row_base   <= w_base;
            r_col        <= '0;
            r_k          <= '0;
            r_acc        <= '0;
          end else if (iStart) begin
            r_acc  <= '0;
            r_corr <= '0;
          end
        end
        ST_FETCH: begin
          if (r_pix_vld) begin
            r_acc <= w_acc_sum;
          end
          if (w_last) begin
            r_frame_rd <= 1'b0;
          end else begin
            r_k <= r_k + TADDR_W'(1);
            if (w_col_wrap) begin
              r_col        <= '0;
              r_row_base   <= r_row_base + ADDR_W'(H_RES);
              r_frame_addr <= r_row_base + ADDR_W'(H_RES);
            end else begin
              r_col        <= r_col + COL_W'(1);
              r_frame_addr <= r_frame_addr + ADDR_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          // Fold in the final product and publish so the result lands with DONE.
          r_acc  <= w_acc_sum;
          r_corr <= w_acc_sum;
        end
        ST_DONE: begin
          r_frame_rd <= 1'b0;
        end
        default: begin
          r_frame_rd <= 1'b0;
        end
      endcase
    end
  end

  assign oFrameRd      = r_frame_rd;
  assign oFrameAddr    = r_frame_addr;
  assign oTmplAddr     = r_k;
  assign oCorr         = r_corr;
  assign oCorrFinished = r_fin;
  assign oBusy         = r_busy;

endmodule

// File: tb/tb_corr_engine.sv
// Directed bench for corr_engine with a one-cycle-latency frame/template memory model.
module tb_corr_engine;

  localparam int ADDR_W  = 19;
  localparam int TADDR_W = 6;
  localparam int CORR_W  = 22;

  logic               clk;
  logic               iRST;
  logic               iStart;
  logic [12:0]        iX;
  logic [12:0]        iY;
  logic               oFrameRd;
  logic [ADDR_W-1:0]  oFrameAddr;
  logic [7:0]         iFramePix;
  logic [TADDR_W-1:0] oTmplAddr;
  logic [7:0]         iTmplPix;
  logic [CORR_W-1:0]  oCorr;
  logic               oCorrFinished;
  logic               oBusy;

  int n_tests = 0;
  int n_fail  = 0;
  int mode    = 0;

  int rd_cnt, rd_first, rd_last, fin_c, fin_cnt, busy_cnt;
  logic [31:0] corr_at_fin;
  logic [ADDR_W-1:0]  addr_log [64];
  logic [TADDR_W-1:0] tmpl_log [64];
  int rise_cyc [4];
  int rises, fins, last_fin, tmpl_bad;
  logic prev_rd;

  corr_engine dut (
    .iCLK(clk), .iRST(iRST), .iStart(iStart), .iX(iX), .iY(iY),
    .oFrameRd(oFrameRd), .oFrameAddr(oFrameAddr), .iFramePix(iFramePix),
    .oTmplAddr(oTmplAddr), .iTmplPix(iTmplPix), .oCorr(oCorr),
    .oCorrFinished(oCorrFinished), .oBusy(oBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (oFrameRd) begin
      case (mode)
        0:       begin iFramePix <= 8'd2;   iTmplPix <= 8'd1; end
        1:       begin iFramePix <= 8'd255; iTmplPix <= 8'd255; end
        default: begin iFramePix <= oFrameAddr[7:0]; iTmplPix <= {2'b00, oTmplAddr}; end
      endcase
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_pattern(input int x, input int y);
    int s = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        s += ((y * 640 + x + r * 640 + c) % 256) * (r * 8 + c);
    return s;
  endfunction

  task automatic run_window(input int x, input int y, input int pulse_c, input int rst_c, input int max_c);
    rd_cnt = 0; rd_first = -1; rd_last = -1; fin_c = -1; fin_cnt = 0; busy_cnt = 0;
    corr_at_fin = 32'hFFFF_FFFF;
    @(negedge clk);
    iX = 13'(x); iY = 13'(y); iStart = 1'b1;
    @(negedge clk);
    iStart = 1'b0;
    for (int c = 1; c <= max_c; c++) begin
      if (c > 1) @(negedge clk);
      if (oFrameRd) begin
        if (rd_cnt < 64) begin
          addr_log[rd_cnt] = oFrameAddr;
          tmpl_log[rd_cnt] = oTmplAddr;
        end
        if (rd_first < 0) rd_first = c;
        rd_last = c;
        rd_cnt++;
      end
      if (oCorrFinished) begin
        fin_cnt++;
        if (fin_c < 0) begin
          fin_c = c;
          corr_at_fin = 32'(oCorr);
        end
      end
      if (oBusy) busy_cnt++;
      iStart = (c == pulse_c) ? 1'b1 : 1'b0;
      if (c == rst_c) begin
        iRST = 1'b1;
        #1;
        check_val("rst_async_outs",
                  {14'd0, oFrameRd, oFrameAddr, oTmplAddr, oCorr, oCorrFinished, oBusy}, 64'd0);
      end
      if (c == rst_c + 2) iRST = 1'b0;
    end
  endtask

  initial begin
    iRST = 1'b1; iStart = 1'b0; iX = 13'd0; iY = 13'd0;
    repeat (3) @(negedge clk);
    check_val("rst_corr",  64'(oCorr), 64'd0);
    check_val("rst_fin",   64'(oCorrFinished), 64'd0);
    check_val("rst_busy",  64'(oBusy), 64'd0);
    check_val("rst_rd",    64'(oFrameRd), 64'd0);
    check_val("rst_addr",  64'(oFrameAddr), 64'd0);
    check_val("rst_taddr", 64'(oTmplAddr), 64'd0);
    iRST = 1'b0;

    // Constant data
    mode = 0;
    run_window(0, 0, 0, 0, 70);
    check_val("const_rd_first", 64'(rd_first), 64'd1);
    check_val("const_rd_last",  64'(rd_last), 64'd64);
    check_val("const_rd_cnt",   64'(rd_cnt), 64'd64);
    check_val("const_fin_cyc",  64'(fin_c), 64'd66);
    check_val("const_fin_cnt",  64'(fin_cnt), 64'd1);
    check_val("const_corr",     64'(corr_at_fin), 64'd128);
    check_val("const_busy_cnt", 64'(busy_cnt), 64'd66);

    // Address sequence with patterned data
    mode = 2;
    run_window(10, 5, 0, 0, 70);
    check_val("addr_first", 64'(addr_log[0]), 64'd3210);
    check_val("addr_8th",   64'(addr_log[7]), 64'd3217);
    check_val("addr_9th",   64'(addr_log[8]), 64'd3850);
    check_val("addr_64th",  64'(addr_log[63]), 64'd7697);
    tmpl_bad = 0;
    for (int i = 0; i < 64; i++) if (int'(tmpl_log[i]) != i) tmpl_bad++;
    check_val("tmpl_lockstep", 64'(tmpl_bad), 64'd0);
    check_val("pattern_corr", 64'(corr_at_fin), 64'(ref_pattern(10, 5)));
    check_val("pattern_fin",  64'(fin_c), 64'd66);

    // Full-scale data
    mode = 1;
    run_window(0, 0, 0, 0, 70);
    check_val("full_corr", 64'(corr_at_fin), 64'd4161600);

    // Bounds
    run_window(633, 0, 0, 0, 5);
    check_val("oob_x_fin",  64'(fin_c), 64'd1);
    check_val("oob_x_corr", 64'(corr_at_fin), 64'd0);
    check_val("oob_x_rd",   64'(rd_cnt), 64'd0);
    check_val("oob_x_busy", 64'(busy_cnt), 64'd1);
    mode = 0;
    run_window(632, 472, 0, 0, 70);
    check_val("edge_rd_cnt", 64'(rd_cnt), 64'd64);
    check_val("edge_first",  64'(addr_log[0]), 64'd302712);
    check_val("edge_last",   64'(addr_log[63]), 64'd307199);
    check_val("edge_corr",   64'(corr_at_fin), 64'd128);
    run_window(0, 473, 0, 0, 5);
    check_val("oob_y_fin",  64'(fin_c), 64'd1);
    check_val("oob_y_corr", 64'(corr_at_fin), 64'd0);
    check_val("oob_y_rd",   64'(rd_cnt), 64'd0);

    // Start pulse mid-window is ignored
    run_window(0, 0, 20, 0, 80);
    check_val("midpulse_fin",     64'(fin_c), 64'd66);
    check_val("midpulse_fin_cnt", 64'(fin_cnt), 64'd1);
    check_val("midpulse_rd_cnt",  64'(rd_cnt), 64'd64);

    // Start held high: back-to-back windows
    rises = 0; fins = 0; last_fin = -1; prev_rd = 1'b0;
    @(negedge clk);
    iX = 13'd0; iY = 13'd0; iStart = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (oFrameRd && !prev_rd && rises < 4) begin
        rise_cyc[rises] = c;
        rises++;
      end
      prev_rd = oFrameRd;
      if (oCorrFinished) begin
        fins++;
        last_fin = c;
      end
    end
    iStart = 1'b0;
    check_val("b2b_fins",  64'(fins), 64'd3);
    check_val("b2b_rises", 64'(rises), 64'd3);
    check_val("b2b_rise2", 64'(rise_cyc[1]), 64'd68);
    check_val("b2b_rise3", 64'(rise_cyc[2]), 64'd135);
    check_val("b2b_last",  64'(last_fin), 64'd200);
    check_val("b2b_corr",  64'(oCorr), 64'd128);

    // Reset mid-window, then a fresh start
    mode = 2;
    run_window(10, 5, 0, 30, 90);
    check_val("rst_mid_fin_cnt", 64'(fin_cnt), 64'd0);
    check_val("rst_mid_corr",    64'(oCorr), 64'd0);
    run_window(10, 5, 0, 0, 70);
    check_val("post_rst_fin",  64'(fin_c), 64'd66);
    check_val("post_rst_corr", 64'(corr_at_fin), 64'(ref_pattern(10, 5)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
